// File: rtl/fib_seq_gen.sv
// fib_seq_gen: streams Fibonacci/Lucas/Tribonacci/user-seeded terms with valid/ready handshake.
// Define FIB_SEQ_SAT_EN to saturate overflowed terms to all-ones instead of wrapping.
module fib_seq_gen #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] seed_a,
  input  logic [WIDTH-1:0] seed_b,
  input  logic [IDX_W-1:0] count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             overflow
);
  localparam int SW = WIDTH + 2;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic fa_q, fa_d, fb_q, fb_d, fc_q, fc_d;
  logic trib_q, trib_d, done_q, done_d, ovf_q, ovf_d;
  logic [IDX_W-1:0] idx_q, idx_d, cnt_q, cnt_d;
  logic [SW-1:0] sum;
  logic sum_f, last;
  logic [WIDTH-1:0] nxt;
  // a is the presented term, b and c the precomputed successors; f* mark terms born from an overflow
  assign sum   = SW'(a_q) + SW'(b_q) + (trib_q ? SW'(c_q) : '0);
  assign sum_f = (|sum[SW-1:WIDTH]) | fa_q | fb_q | (trib_q & fc_q);
`ifdef FIB_SEQ_SAT_EN
  assign nxt = sum_f ? '1 : sum[WIDTH-1:0];
`else
  assign nxt = sum[WIDTH-1:0];
`endif
  assign last      = idx_q == cnt_q - IDX_W'(1);
  assign out_valid = state_q == RUN;
  assign busy      = state_q == RUN;
  assign out_last  = out_valid && last;
  assign out_data  = a_q;
  assign out_index = idx_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    fa_d = fa_q;
    fb_d = fb_q;
    fc_d = fc_q;
    trib_d = trib_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    done_d = 1'b0;
    if (state_q == IDLE && start) begin
      ovf_d = 1'b0;
      done_d = count == '0;
      if (count != '0) begin
        state_d = RUN;
        a_d = mode == 2'b11 ? seed_a : mode == 2'b01 ? WIDTH'(2) : '0;
        b_d = mode == 2'b11 ? seed_b : mode == 2'b10 ? '0 : WIDTH'(1);
        c_d = WIDTH'(1);
        {fa_d, fb_d, fc_d} = 3'b000;
        trib_d = mode == 2'b10;
        idx_d = '0;
        cnt_d = count;
      end
    end else if (state_q == RUN && out_ready) begin
      state_d = last ? IDLE : RUN;
      done_d = last;
      if (!last) begin
        idx_d = idx_q + IDX_W'(1);
        a_d = b_q;
        fa_d = fb_q;
        ovf_d = ovf_q | fb_q;
        b_d = trib_q ? c_q : nxt;
        fb_d = trib_q ? fc_q : sum_f;
        c_d = trib_q ? nxt : c_q;
        fc_d = trib_q ? sum_f : fc_q;
      end
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      {fa_q, fb_q, fc_q} <= 3'b000;
      trib_q <= 1'b0;
      idx_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      {fa_q, fb_q, fc_q} <= {fa_d, fb_d, fc_d};
      trib_q <= trib_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_fib_seq_gen.sv
// tb_fib_seq_gen: directed vector table, hand sequences and randomized runs against a term-list model.
module tb_fib_seq_gen;
  logic clock = 1'b0, reset, start, out_ready, out_valid, out_last, busy, done, overflow;
  logic [1:0] mode;
  logic [7:0] seed_a, seed_b, count, out_data, out_index;
  int nvec = 0, nerr = 0;

  fib_seq_gen #(.WIDTH(8), .IDX_W(8)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .seed_a(seed_a), .seed_b(seed_b),
    .count(count), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done), .overflow(overflow));

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] m;
    logic [7:0] sa, sb, n;
    int stall_idx, stall_len;
    logic [9:0][7:0] exp;
  } vec_t;
  vec_t tab[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input logic exp_done);
    chk("idle valid", 32'(out_valid), 0);
    chk("idle busy", 32'(busy), 0);
    chk("idle last", 32'(out_last), 0);
    chk("idle done", 32'(done), 32'(exp_done));
  endtask

  // Called at a negedge; returns at a negedge after the done pulse has been checked.
  task automatic run(input logic [1:0] m, input logic [7:0] sa, input logic [7:0] sb,
                     input logic [7:0] n, input int pct, input int stall_idx, input int stall_len,
                     input bit use_tab, input logic [9:0][7:0] texp);
    int t[$];
    bit ovs[$];
    bit seen = 0;
    int s, k = 0, cyc = 0, stalled = 0;
    bit rdy;
    case (m)
      2'd0: t = '{0, 1};
      2'd1: t = '{2, 1};
      2'd2: t = '{0, 0, 1};
      default: t = '{int'(sa), int'(sb)};
    endcase
    foreach (t[i]) ovs.push_back(1'b0);
    for (int i = t.size(); i < int'(n); i++) begin
      s = t[i-1] + t[i-2] + (m == 2'd2 ? t[i-3] : 0);
      if (s > 255) seen = 1;
`ifdef FIB_SEQ_SAT_EN
      t.push_back(seen ? 255 : s);
`else
      t.push_back(s % 256);
`endif
      ovs.push_back(seen);
    end
    start = 1; mode = m; seed_a = sa; seed_b = sb; count = n;
    @(negedge clock);
    start = 0;
    while (k < int'(n) && cyc < 1000) begin
      chk("valid", 32'(out_valid), 1);
      chk("busy", 32'(busy), 1);
      chk("done early", 32'(done), 0);
      chk("data", 32'(out_data), use_tab ? 32'(texp[k]) : 32'(t[k]));
      chk("index", 32'(out_index), 32'(k));
      chk("last", 32'(out_last), 32'(k == int'(n) - 1));
      chk("overflow", 32'(overflow), 32'(ovs[k]));
      if (k == stall_idx && stalled < stall_len) begin
        rdy = 0;
        stalled++;
      end else rdy = $urandom_range(99) < pct;
      out_ready = rdy;
      start = (k < int'(n) - 1) && $urandom_range(3) == 0;
      mode = 2'($urandom); seed_a = 8'($urandom); seed_b = 8'($urandom); count = 8'($urandom);
      @(negedge clock);
      if (rdy) k++;
      cyc++;
    end
    if (k < int'(n)) chk("timeout terms", 32'(k), 32'(n));
    start = 0;
    out_ready = 1'($urandom);
    chk_idle(1);
    @(negedge clock);
    chk_idle(0);
  endtask

  initial begin
    tab[0] = '{2'd0, 8'd0, 8'd0, 8'd10, -1, 0,
               {8'd34, 8'd21, 8'd13, 8'd8, 8'd5, 8'd3, 8'd2, 8'd1, 8'd1, 8'd0}};
    tab[1] = '{2'd1, 8'd0, 8'd0, 8'd5, -1, 0,
               {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd7, 8'd4, 8'd3, 8'd1, 8'd2}};
    tab[2] = '{2'd2, 8'd0, 8'd0, 8'd7, -1, 0,
               {8'd0, 8'd0, 8'd0, 8'd7, 8'd4, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0}};
    tab[3] = '{2'd3, 8'd5, 8'd3, 8'd4, 1, 3,
               {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd11, 8'd8, 8'd3, 8'd5}};
    reset = 1; start = 0; mode = 0; seed_a = 0; seed_b = 0; count = 0; out_ready = 1;
    @(negedge clock);
    @(negedge clock);
    chk("rst data", 32'(out_data), 0);
    chk("rst index", 32'(out_index), 0);
    chk("rst overflow", 32'(overflow), 0);
    chk_idle(0);
    reset = 0;
    foreach (tab[i]) run(tab[i].m, tab[i].sa, tab[i].sb, tab[i].n, 100,
                         tab[i].stall_idx, tab[i].stall_len, 1, tab[i].exp);
    // count of zero: done pulse only
    start = 1; mode = 0; count = 0;
    @(negedge clock);
    start = 0;
    chk_idle(1);
    @(negedge clock);
    chk_idle(0);
    // 8-bit overflow: index 14 is 377 mod 256, or saturated
    start = 1; mode = 0; count = 16; out_ready = 1;
    @(negedge clock);
    start = 0;
    repeat (14) @(negedge clock);
    chk("ovf idx", 32'(out_index), 14);
    chk("ovf flag", 32'(overflow), 1);
`ifdef FIB_SEQ_SAT_EN
    chk("ovf t14", 32'(out_data), 255);
`else
    chk("ovf t14", 32'(out_data), 121);
`endif
    @(negedge clock);
    @(negedge clock);
    chk_idle(1);
    run(2'd0, 0, 0, 16, 60, -1, 0, 0, '0);
    run(2'd0, 0, 0, 10, 100, -1, 0, 0, '0);
    // reset mid-sequence at index 3
    start = 1; mode = 0; count = 10;
    @(negedge clock);
    start = 0;
    repeat (3) @(negedge clock);
    chk("pre-rst idx", 32'(out_index), 3);
    reset = 1;
    #1;
    chk("arst data", 32'(out_data), 0);
    chk("arst index", 32'(out_index), 0);
    chk_idle(0);
    @(negedge clock);
    reset = 0;
    chk_idle(0);
    @(negedge clock);
    chk_idle(0);
    run(tab[0].m, 0, 0, tab[0].n, 100, -1, 0, 1, tab[0].exp);
    for (int r = 0; r < 25; r++)
      run(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom_range(40, 1)),
          $urandom_range(100, 30), -1, 0, 0, '0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
